pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Sequential next-PC controller for the CPU's branch/jump unit. It holds the PC and the 2-bit status register {Z,N}, and resolves the seven branch/jump classes on the 3-bit `bnj` code. It also runs the multi-cycle memory-indirect jump (jm), which reads its target from data memory and stalls fetch until the read returns. It sits between the instruction decoder and the fetch stage, and drives the link-register write for balz.

## Interface
- WIDTH, 32, PC/address/data width
- RESET_PC, 0, PC value loaded on reset

- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- instr_valid  in  1  decoded instruction present this cycle
- bnj  in  3  class: 000 none, 001 j, 010 beq, 011 bgez, 100 brn, 101 jm, 110 balz, 111 none
- set_stat  in  1  instruction updates status register
- alu_zero  in  1  ALU zero flag of current instruction
- alu_neg  in  1  ALU negative flag of current instruction
- branch_target  in  WIDTH  PC-relative target (beq/bgez/balz)
- jump_target  in  WIDTH  absolute target (j); pointer address (jm)
- reg_target  in  WIDTH  register-sourced target (brn)
- mem_rdata  in  WIDTH  data memory read data
- mem_rvalid  in  1  mem_rdata valid this cycle
- pc  out  WIDTH  current PC
- stat  out  2  status register {Z,N}
- stall  out  1  fetch must hold; instr_valid ignored
- flush  out  1  one-cycle pulse after any taken redirect
- mem_req  out  1  jm read request, level
- mem_addr  out  WIDTH  jm read address
- link_we  out  1  link-register write strobe
- link_data  out  WIDTH  link value (PC+4 of the balz)

## Operation
- Clock and reset: one clock (clk). Reset is synchronous, active-high (reset).
- Reset values: pc=RESET_PC, stat=00, state RUN, stall=0, flush=0, mem_req=0, mem_addr=0, link_we=0, link_data=0.
- Instruction acceptance: an instruction is accepted when state is RUN, instr_valid=1 and stall=0.
- Taken conditions, evaluated on the pre-update stat:
  - beq: Z=1 -> branch_target
  - bgez: N=0 -> branch_target
  - brn: N=1 -> reg_target
  - balz: Z=1 -> branch_target, plus link
  - j: always -> jump_target
  - jm: always, via memory read
- Not taken, none or 111: pc <= pc+4, modulo 2^WIDTH (wraps silently).
- Status update: if an accepted instruction has set_stat=1, then stat <= {alu_zero, alu_neg}. This happens in the same edge as any branch resolution; the branch still sees the old stat.
- balz: when taken, link_we=1 and link_data=pc+4 for exactly one cycle. When not taken, link_we stays 0.
- FSM states:
  - RUN: normal acceptance.
  - JM_WAIT: entered on accepted jm. Sets mem_req=1, mem_addr=jump_target (captured), stall=1. Held indefinitely until mem_rvalid=1. On that edge: pc <= mem_rdata, state -> RUN, mem_req=0, stall=0, flush=1.
- mem_rvalid outside JM_WAIT is ignored.
- flush pulses for one cycle after every taken beq/bgez/brn/balz/j, and after jm completion. It stays 0 for fall-through.

## Timing
- Accepted non-jm instruction at edge N: pc, stat, flush and link_we all take their new values after edge N. Latency is 1 cycle.
- Accepted jm at edge N: mem_req=1 and stall=1 from cycle N+1. mem_rvalid sampled at edge N+k gives pc=mem_rdata from cycle N+k+1. Minimum jm latency is 2 cycles (mem_rvalid in the first JM_WAIT cycle).
- jm with mem_rvalid at edge N+1: pc updated after N+1, and the next instruction can be accepted at edge N+2.
- instr_valid while stall=1: no effect on pc or stat.
- Reset during JM_WAIT: all outputs return to reset values after the edge. A pending response is discarded, and a late mem_rvalid is ignored.
- Reset has priority over every other event in the same edge.
- All outputs are registered; none depends combinationally on inputs.

## Test plan
- Reset, then 3 instructions with bnj=000 -> pc: 0, 4, 8, 12. flush=0 throughout.
- Accept set_stat=1 with alu_zero=1 (stat=10). Next, beq with branch_target=0x100 -> pc=0x100 and flush=1 for one cycle. Then bgez with branch_target=0x200 -> pc=0x200 (N=0).
- stat=01, then balz at pc=0x40 -> not taken: pc=0x44, link_we=0. Then stat=10 and balz at pc=0x80 with branch_target=0x300 -> pc=0x300, link_we=1, link_data=0x84.
- jm with jump_target=0x20 at edge N: mem_req=1, mem_addr=0x20, stall=1. Hold mem_rvalid=0 for 3 cycles with instr_valid=1 -> pc unchanged. Then mem_rvalid=1 with mem_rdata=0x500 -> pc=0x500, stall=0, flush=1.
- pc=0xFFFFFFFC with bnj=000 -> pc=0. brn with stat=01 and reg_target=0x1234 -> pc=0x1234.
- Assert reset during JM_WAIT, then mem_rvalid=1 with mem_rdata=0x999 one cycle after reset is released -> pc=RESET_PC, mem_req=0, stall=0, and the response is ignored.

Source files
------------

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : pc_sequencer
// Purpose : Next-PC controller with {Z,N} status, branch/jump resolution and
//           a memory-indirect jump that stalls fetch until the read returns.
// Revision: 1.0  initial release
// ============================================================================
module pc_sequencer #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [2:0]       bnj,
    input  logic             set_stat,
    input  logic             alu_zero,
    input  logic             alu_neg,
    input  logic [WIDTH-1:0] branch_target,
    input  logic [WIDTH-1:0] jump_target,
    input  logic [WIDTH-1:0] reg_target,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_rvalid,
    output logic [WIDTH-1:0] pc,
    output logic [1:0]       stat,
    output logic             stall,
    output logic             flush,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    output logic             link_we,
    output logic [WIDTH-1:0] link_data
);

    localparam logic [2:0] C_BNJ_J    = 3'b001;
    localparam logic [2:0] C_BNJ_BEQ  = 3'b010;
    localparam logic [2:0] C_BNJ_BGEZ = 3'b011;
    localparam logic [2:0] C_BNJ_BRN  = 3'b100;
    localparam logic [2:0] C_BNJ_JM   = 3'b101;
    localparam logic [2:0] C_BNJ_BALZ = 3'b110;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_JM_WAIT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] w_pc_plus4;
    logic [1:0]       w_stat_next;
    logic             w_stall_next;
    logic             w_flush_next;
    logic             w_mem_req_next;
    logic [WIDTH-1:0] w_mem_addr_next;
    logic             w_link_we_next;
    logic [WIDTH-1:0] w_link_data_next;
    logic             w_accept;

    assign w_pc_plus4 = pc + WIDTH'(4);
    assign w_accept   = (r_state == ST_RUN) && instr_valid && !stall;

    // Branch conditions use the current stat, before this instruction's update.
    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = pc;
        w_stat_next      = stat;
        w_stall_next     = stall;
        w_flush_next     = 1'b0;
        w_mem_req_next   = mem_req;
        w_mem_addr_next  = mem_addr;
        w_link_we_next   = 1'b0;
        w_link_data_next = link_data;
        case (r_state)
            ST_RUN: begin
                if (w_accept) begin
                    if (set_stat) begin
                        w_stat_next = {alu_zero, alu_neg};
                    end
                    w_pc_next = w_pc_plus4;
                    case (bnj)
                        C_BNJ_J: begin
                            w_pc_next    = jump_target;
                            w_flush_next = 1'b1;
                        end
                        C_BNJ_BEQ: if (stat[1]) begin
                            w_pc_next    = branch_target;
                            w_flush_next = 1'b1;
                        end
                        C_BNJ_BGEZ: if (!stat[0]) begin
                            w_pc_next    = branch_target;
                            w_flush_next = 1'b1;
                        end
                        C_BNJ_BRN: if (stat[0]) begin
                            w_pc_next    = reg_target;
                            w_flush_next = 1'b1;
                        end
                        C_BNJ_JM: begin
                            w_pc_next       = pc;
                            w_state_next    = ST_JM_WAIT;
                            w_stall_next    = 1'b1;
                            w_mem_req_next  = 1'b1;
                            w_mem_addr_next = jump_target;
                        end
                        C_BNJ_BALZ: if (stat[1]) begin
                            w_pc_next        = branch_target;
                            w_flush_next     = 1'b1;
                            w_link_we_next   = 1'b1;
                            w_link_data_next = w_pc_plus4;
                        end
                        default: ;
                    endcase
                end
            end
            ST_JM_WAIT: begin
                if (mem_rvalid) begin
                    w_pc_next      = mem_rdata;
                    w_state_next   = ST_RUN;
                    w_stall_next   = 1'b0;
                    w_mem_req_next = 1'b0;
                    w_flush_next   = 1'b1;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_RUN;
            pc        <= RESET_PC;
            stat      <= 2'b00;
            stall     <= 1'b0;
            flush     <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            link_we   <= 1'b0;
            link_data <= '0;
        end else begin
            r_state   <= w_state_next;
            pc        <= w_pc_next;
            stat      <= w_stat_next;
            stall     <= w_stall_next;
            flush     <= w_flush_next;
            mem_req   <= w_mem_req_next;
            mem_addr  <= w_mem_addr_next;
            link_we   <= w_link_we_next;
            link_data <= w_link_data_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_sequencer
// Purpose : Vector table, hand-written jm sequences and randomized model check.
// Revision: 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int          WIDTH    = 32;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset, instr_valid, set_stat, alu_zero, alu_neg, mem_rvalid;
    logic [2:0]  bnj;
    logic [31:0] branch_target, jump_target, reg_target, mem_rdata;
    logic [31:0] pc, mem_addr, link_data;
    logic [1:0]  stat;
    logic        stall, flush, mem_req, link_we;

    int tests = 0;
    int fails = 0;

    pc_sequencer #(.WIDTH(WIDTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .bnj(bnj),
        .set_stat(set_stat), .alu_zero(alu_zero), .alu_neg(alu_neg),
        .branch_target(branch_target), .jump_target(jump_target),
        .reg_target(reg_target), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .pc(pc), .stat(stat), .stall(stall), .flush(flush), .mem_req(mem_req),
        .mem_addr(mem_addr), .link_we(link_we), .link_data(link_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  bnj;
        logic        ss, z, n;
        logic [31:0] tgt;
        logic [31:0] exp_pc;
        logic [1:0]  exp_stat;
        logic        exp_flush, exp_lwe;
        logic [31:0] exp_ldata;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(logic [2:0] b, logic ss, logic z, logic n, logic [31:0] tgt,
                                logic [31:0] epc, logic [1:0] est, logic efl, logic elwe,
                                logic [31:0] eld);
        vec_t v;
        v.bnj = b; v.ss = ss; v.z = z; v.n = n; v.tgt = tgt;
        v.exp_pc = epc; v.exp_stat = est; v.exp_flush = efl; v.exp_lwe = elwe; v.exp_ldata = eld;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; instr_valid = 0; bnj = 3'b000; set_stat = 0; alu_zero = 0; alu_neg = 0;
        branch_target = 0; jump_target = 0; reg_target = 0; mem_rdata = 0; mem_rvalid = 0;
    endtask

    task automatic issue(logic [2:0] b, logic [31:0] tgt);
        instr_valid = 1; bnj = b; set_stat = 0;
        branch_target = (b == 3'd2 || b == 3'd3 || b == 3'd6) ? tgt : 32'hBAD0_0000;
        jump_target   = (b == 3'd1 || b == 3'd5) ? tgt : 32'hBAD1_0000;
        reg_target    = (b == 3'd4) ? tgt : 32'hBAD2_0000;
    endtask

    // Reference model: architectural state updated from the rules, not the RTL.
    logic [31:0] m_pc, m_addr, m_ldata;
    logic [1:0]  m_stat;
    logic        m_busy, m_flush, m_lwe;

    function automatic bit is_taken(logic [2:0] b, logic [1:0] s);
        return (b == 3'd1) || (b == 3'd2 && s[1]) || (b == 3'd3 && !s[0]) ||
               (b == 3'd4 && s[0]) || (b == 3'd6 && s[1]);
    endfunction

    task automatic model_edge();
        logic [1:0] old_stat;
        old_stat = m_stat;
        m_flush = 0;
        m_lwe = 0;
        if (reset) begin
            m_pc = RESET_PC; m_stat = 0; m_busy = 0; m_addr = 0; m_ldata = 0;
        end else if (m_busy) begin
            if (mem_rvalid) begin
                m_pc = mem_rdata; m_busy = 0; m_flush = 1;
            end
        end else if (instr_valid) begin
            if (set_stat) m_stat = {alu_zero, alu_neg};
            if (bnj == 3'd5) begin
                m_busy = 1; m_addr = jump_target;
            end else if (is_taken(bnj, old_stat)) begin
                if (bnj == 3'd6) begin
                    m_lwe = 1; m_ldata = m_pc + 32'd4;
                end
                m_pc = (bnj == 3'd1) ? jump_target : (bnj == 3'd4) ? reg_target : branch_target;
                m_flush = 1;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        idle();
        reset = 1;
        tick();
        tick();
        chk("reset pc", pc, RESET_PC);
        chk("reset stat", {30'd0, stat}, 0);
        chk("reset stall/flush/mem_req/link_we", {28'd0, stall, flush, mem_req, link_we}, 0);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset link_data", link_data, 0);
        reset = 0;

        vecs[0]  = mk(3'd0, 0, 0, 0, 32'h0,        32'h4,        2'b00, 0, 0, 0);
        vecs[1]  = mk(3'd0, 0, 0, 0, 32'h0,        32'h8,        2'b00, 0, 0, 0);
        vecs[2]  = mk(3'd0, 0, 0, 0, 32'h0,        32'hC,        2'b00, 0, 0, 0);
        vecs[3]  = mk(3'd0, 1, 1, 0, 32'h0,        32'h10,       2'b10, 0, 0, 0);
        vecs[4]  = mk(3'd2, 0, 0, 0, 32'h100,      32'h100,      2'b10, 1, 0, 0);
        vecs[5]  = mk(3'd3, 0, 0, 0, 32'h200,      32'h200,      2'b10, 1, 0, 0);
        vecs[6]  = mk(3'd1, 0, 0, 0, 32'h3C,       32'h3C,       2'b10, 1, 0, 0);
        vecs[7]  = mk(3'd0, 1, 0, 1, 32'h0,        32'h40,       2'b01, 0, 0, 0);
        vecs[8]  = mk(3'd6, 0, 0, 0, 32'h999,      32'h44,       2'b01, 0, 0, 0);
        vecs[9]  = mk(3'd1, 1, 1, 0, 32'h80,       32'h80,       2'b10, 1, 0, 0);
        vecs[10] = mk(3'd6, 0, 0, 0, 32'h300,      32'h300,      2'b10, 1, 1, 32'h84);
        vecs[11] = mk(3'd0, 0, 0, 0, 32'h0,        32'h304,      2'b10, 0, 0, 0);
        vecs[12] = mk(3'd2, 1, 0, 1, 32'h500,      32'h500,      2'b01, 1, 0, 0);
        vecs[13] = mk(3'd4, 0, 0, 0, 32'h1234,     32'h1234,     2'b01, 1, 0, 0);
        vecs[14] = mk(3'd7, 0, 0, 0, 32'h0,        32'h1238,     2'b01, 0, 0, 0);
        vecs[15] = mk(3'd3, 0, 0, 0, 32'h10,       32'h123C,     2'b01, 0, 0, 0);
        vecs[16] = mk(3'd1, 0, 0, 0, 32'hFFFFFFFC, 32'hFFFFFFFC, 2'b01, 1, 0, 0);
        vecs[17] = mk(3'd0, 0, 0, 0, 32'h0,        32'h0,        2'b01, 0, 0, 0);

        for (int i = 0; i < 18; i++) begin
            issue(vecs[i].bnj, vecs[i].tgt);
            set_stat = vecs[i].ss; alu_zero = vecs[i].z; alu_neg = vecs[i].n;
            tick();
            chk($sformatf("vec%0d pc", i), pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d stat", i), {30'd0, stat}, {30'd0, vecs[i].exp_stat});
            chk($sformatf("vec%0d flush", i), {31'd0, flush}, {31'd0, vecs[i].exp_flush});
            chk($sformatf("vec%0d link_we", i), {31'd0, link_we}, {31'd0, vecs[i].exp_lwe});
            if (vecs[i].exp_lwe) chk($sformatf("vec%0d link_data", i), link_data, vecs[i].exp_ldata);
        end

        // jm with a three-cycle memory delay; instructions during stall are ignored
        idle();
        issue(3'd5, 32'h20);
        tick();
        chk("jm mem_req", {31'd0, mem_req}, 1);
        chk("jm mem_addr", mem_addr, 32'h20);
        chk("jm stall", {31'd0, stall}, 1);
        issue(3'd1, 32'h700);
        set_stat = 1; alu_zero = 1; alu_neg = 1; mem_rdata = 32'h777;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("jm wait pc", pc, 32'h0);
            chk("jm wait stat", {30'd0, stat}, 32'd1);
            chk("jm wait stall", {31'd0, stall}, 1);
        end
        idle();
        mem_rvalid = 1; mem_rdata = 32'h500;
        tick();
        chk("jm done pc", pc, 32'h500);
        chk("jm done stall/flush/mem_req", {29'd0, stall, flush, mem_req}, 32'b010);
        mem_rvalid = 0;
        tick();
        chk("jm flush one cycle", {31'd0, flush}, 0);

        // Minimum-latency jm, then immediate acceptance, then stray mem_rvalid
        issue(3'd5, 32'h44);
        tick();
        idle();
        mem_rvalid = 1; mem_rdata = 32'h900;
        tick();
        chk("jm fast pc", pc, 32'h900);
        chk("jm fast stall", {31'd0, stall}, 0);
        mem_rvalid = 0;
        issue(3'd0, 32'h0);
        tick();
        chk("post-jm accept pc", pc, 32'h904);
        idle();
        mem_rvalid = 1; mem_rdata = 32'hABC;
        tick();
        chk("stray rvalid pc", pc, 32'h904);
        chk("stray rvalid flush", {31'd0, flush}, 0);

        // Reset during JM_WAIT discards the pending response
        idle();
        issue(3'd5, 32'h30);
        tick();
        idle();
        reset = 1;
        tick();
        chk("jm reset pc", pc, RESET_PC);
        chk("jm reset stall/mem_req", {30'd0, stall, mem_req}, 0);
        reset = 0;
        tick();
        mem_rvalid = 1; mem_rdata = 32'h999;
        tick();
        chk("late rvalid pc", pc, RESET_PC);
        chk("late rvalid stall/mem_req/flush", {29'd0, stall, mem_req, flush}, 0);

        // Randomized run against the reference model
        idle();
        reset = 1;
        model_edge();
        tick();
        for (int c = 0; c < 400; c++) begin
            reset         = ($urandom_range(0, 49) == 0);
            instr_valid   = ($urandom_range(0, 9) < 7);
            bnj           = 3'($urandom_range(0, 7));
            set_stat      = 1'($urandom);
            alu_zero      = 1'($urandom);
            alu_neg       = 1'($urandom);
            branch_target = $urandom & 32'hFFFF_FFFC;
            jump_target   = $urandom & 32'hFFFF_FFFC;
            reg_target    = $urandom & 32'hFFFF_FFFC;
            mem_rdata     = $urandom & 32'hFFFF_FFFC;
            mem_rvalid    = ($urandom_range(0, 3) == 0);
            model_edge();
            tick();
            chk("rnd pc", pc, m_pc);
            chk("rnd stat", {30'd0, stat}, {30'd0, m_stat});
            chk("rnd stall/mem_req", {30'd0, stall, mem_req}, {30'd0, m_busy, m_busy});
            chk("rnd flush", {31'd0, flush}, {31'd0, m_flush});
            chk("rnd link_we", {31'd0, link_we}, {31'd0, m_lwe});
            if (m_busy) chk("rnd mem_addr", mem_addr, m_addr);
            if (m_lwe) chk("rnd link_data", link_data, m_ldata);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
